gcd_rr_scheduler: RTL
=====================

Name: gcd_rr_scheduler

Overview:
- Shares one iterative Euclidean GCD engine among NREQ requesters.
- Round-robin arbitration selects one request at a time. The block sequences the engine through load, iterate and respond phases, then returns the result tagged with the requester index.
- Sits between the client blocks and the GCD datapath, replacing per-client GCD units.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand/result width.
- IDW, 2, requester-id width, equal to clog2(NREQ).
- SW, 6, step-counter width; must hold the maximum Euclid step count for W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_x  in  NREQ*W  operand x; requester i uses bits [i*W +: W].
- req_y  in  NREQ*W  operand y, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester the result belongs to.
- rsp_gcd  out  W  gcd(x,y).
- rsp_steps  out  SW  number of Euclid iterations taken.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (synchronous, active-high; clock clk): state=IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_gcd=0, rsp_steps=0, busy=0, internal a/b/step=0. A reset mid-operation abandons the job. No response is emitted for it.
- States are IDLE, ITER and DONE.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching ptr, ptr+1, … NREQ-1, then 0, … ptr-1.
  - req_ready[g]=1 combinationally. All other bits are 0. req_ready is all-zero outside IDLE or when no valid is present.
  - On the accepting edge: a<=max(x,y), b<=min(x,y), step<=0, id<=g, ptr<=(g+1) mod NREQ, state<=ITER.
- ITER, one Euclid step per cycle:
  - If b==0: rsp_gcd<=a, rsp_steps<=step, rsp_id<=id, rsp_valid<=1, state<=DONE.
  - Otherwise: a<=b, b<=a mod b, step<=step+1 (saturating at all-ones).
- DONE:
  - rsp_valid, rsp_id, rsp_gcd and rsp_steps hold stable until rsp_valid&rsp_ready.
  - On that edge: rsp_valid<=0, state<=IDLE.
  - No request is accepted in the same cycle, so there is a mandatory one-cycle bubble.
- Latency: a job needing k modulo steps asserts rsp_valid k+1 cycles after its accepting edge.
- Zero operands:
  - gcd(0,y)=y with k=0.
  - gcd(0,0)=0 with k=0.
  - gcd(x,x)=x with k=1.
- Requesters must hold req_valid and operands stable until accepted. Operand changes after acceptance have no effect.
- rsp_gcd, rsp_id and rsp_steps retain their last values after the handshake. They are meaningful only while rsp_valid=1.
- Fairness: a continuously asserting requester waits at most NREQ-1 jobs.

Test Plan:
- Single job: req 0, x=48, y=18 → accepted with ptr 0→1. rsp_valid rises 4 cycles after acceptance with rsp_gcd=6, rsp_steps=3, rsp_id=0.
- Zero and equal operands: (0,35) → gcd=35, steps=0, latency 1. (0,0) → gcd=0. (17,17) → gcd=17, steps=1.
- Round-robin: all 4 requesters valid continuously from reset → acceptance order 0,1,2,3,0. req_ready is never multi-hot.
- Backpressure: rsp_ready held low 5 cycles after (270,192) completes → rsp_valid stays 1 and rsp_gcd stays 6 throughout. No req_ready is asserted until 1 cycle after the handshake.
- Reset mid-operation: assert reset during ITER of (1071,462) → next cycle state=IDLE, rsp_valid=0, ptr=0. No response is produced for the aborted job.
- Worst case: consecutive Fibonacci operands (2971215073, 1836311903) → gcd=1, steps=45, busy high for the whole job.

Source files
------------

// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end for one shared iterative Euclidean GCD engine.
// Accepts one request at a time, iterates one modulo step per cycle, and returns a tagged result.
module gcd_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2,
  parameter int SW   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_gcd,
  output logic [SW-1:0]     rsp_steps,
  output logic              busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // The sender holds valid and its payload stable until then; ready never depends on
  // a transfer in the same cycle. A requester's valid may assert before its ready.

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           grant_found;
  logic [W-1:0]   sel_x, sel_y;
  logic [W-1:0]   a, b;
  logic [SW-1:0]  step;
  logic [IDW-1:0] id;
  logic           accept;

  // Search starts at ptr and wraps, so the most recently served requester goes last.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    idx_w       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (!grant_found && req_valid[idx_w]) begin
        grant_found = 1'b1;
        grant       = idx_w;
      end
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_x = req_x[i*W +: W];
        sel_y = req_y[i*W +: W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant] = 1'b1;
          state_nxt        = ITER;
        end
      end
      ITER:    if (b == '0) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && grant_found;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      a         <= '0;
      b         <= '0;
      step      <= '0;
      id        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gcd   <= '0;
      rsp_steps <= '0;
    end else begin
      if (accept) begin
        a    <= (sel_x > sel_y) ? sel_x : sel_y;
        b    <= (sel_x > sel_y) ? sel_y : sel_x;
        step <= '0;
        id   <= grant;
        ptr  <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
      end
      if (state == ITER) begin
        if (b == '0) begin
          rsp_gcd   <= a;
          rsp_steps <= step;
          rsp_id    <= id;
          rsp_valid <= 1'b1;
        end else begin
          a <= b;
          b <= a % b;
          if (step != '1) step <= step + SW'(1);
        end
      end
      if (state == DONE && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule
